// File: rtl/clock_pkg.sv
// Shared types and constants for the HH:MM clock mode/sequencing logic.
// State encoding doubles as the external mode output.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HRS = 2'b01,
    ST_SET_MIN = 2'b10
  } state_e;

  localparam int unsigned NUM_DIGITS = 4;

  localparam int unsigned DIG_MIN_U = 0;
  localparam int unsigned DIG_MIN_D = 1;
  localparam int unsigned DIG_HRS_U = 2;
  localparam int unsigned DIG_HRS_D = 3;

  localparam logic [NUM_DIGITS-1:0] MASK_HRS =
    NUM_DIGITS'((1 << DIG_HRS_U) | (1 << DIG_HRS_D));
  localparam logic [NUM_DIGITS-1:0] MASK_MIN =
    NUM_DIGITS'((1 << DIG_MIN_U) | (1 << DIG_MIN_D));

  // Digits belonging to the field being edited in a given state.
  function automatic logic [NUM_DIGITS-1:0] mask_for(state_e st);
    logic [NUM_DIGITS-1:0] m;
    m = '0;
    case (st)
      ST_SET_HRS: m = MASK_HRS;
      ST_SET_MIN: m = MASK_MIN;
      default:    m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ms_timer.sv
// Millisecond tick counter: counts tick strobes while enabled, flags the tick
// that reaches LIMIT and reloads to RELOAD on that same tick. Clear wins.
module ms_timer #(
  parameter int unsigned CNT_W  = 14,
  parameter int unsigned LIMIT  = 250,
  parameter int unsigned RELOAD = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic clr,
  input  logic en,
  output logic done_c
);

  // Elaboration-time guard: the counter must be able to hold LIMIT.
  if (LIMIT == 0 || LIMIT >= (1 << CNT_W) || RELOAD >= LIMIT) begin : g_bad_cfg
    $error("ms_timer: LIMIT/RELOAD do not fit CNT_W");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    done_c = 1'b0;
    cnt_d  = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && tick) begin
      if (cnt_q == CNT_W'(LIMIT - 1)) begin
        done_c = 1'b1;
        cnt_d  = CNT_W'(RELOAD);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// RUN/SET_HRS/SET_MIN sequencer: turns debounced buttons into one-cycle
// increment strobes with auto-repeat, freezes seconds and blinks the edited field.
module time_set_controller
  import clock_pkg::*;
#(
  parameter int unsigned BLINK_HALF_MS   = 250,
  parameter int unsigned REPEAT_DELAY_MS = 600,
  parameter int unsigned REPEAT_RATE_MS  = 150,
  parameter int unsigned IDLE_TIMEOUT_MS = 10000,
  parameter int unsigned CNT_W           = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_ms,
  input  logic       mode_lvl,
  input  logic       adj_lvl,
  output logic       inc_min,
  output logic       inc_hrs,
  output logic       clear_sec,
  output logic       run_en,
  output logic [3:0] blank_mask,
  output logic [1:0] mode
);

  state_e     state_q, state_d;
  logic       mode_q, adj_q;
  logic       armed_q, armed_d;
  logic       phase_q, phase_d;
  logic       inc_min_q, inc_min_d;
  logic       inc_hrs_q, inc_hrs_d;
  logic       clear_sec_q, clear_sec_d;
  logic       run_en_q, run_en_d;
  logic [3:0] blank_mask_q, blank_mask_d;

  logic mode_press, adj_press, in_set, entry, adj_act;
  logic blink_clr, blink_done;
  logic rep_clr, rep_en, rep_done;
  logic idle_clr, idle_done;

  assign mode_press = mode_lvl & ~mode_q;
  assign adj_press  = adj_lvl & ~adj_q;
  assign in_set     = (state_q != ST_RUN);

  // Idle timer restarts on any button activity; held adj keeps it at zero.
  assign idle_clr = ~in_set | mode_press | adj_lvl;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (mode_press) state_d = ST_SET_HRS;
      end
      ST_SET_HRS: begin
        if (mode_press)     state_d = ST_SET_MIN;
        else if (idle_done) state_d = ST_RUN;
      end
      ST_SET_MIN: begin
        if (mode_press || idle_done) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign entry = (state_d != state_q);

  // A mode change in the same cycle swallows any adjust activity.
  assign adj_act   = in_set & adj_press & armed_q & ~entry;
  assign blink_clr = ~in_set | entry;
  assign rep_clr   = ~in_set | entry | ~adj_lvl | adj_act;
  assign rep_en    = armed_q & adj_lvl;

  ms_timer #(
    .CNT_W (CNT_W),
    .LIMIT (BLINK_HALF_MS),
    .RELOAD(0)
  ) u_blink_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_ms),
    .clr   (blink_clr),
    .en    (in_set),
    .done_c(blink_done)
  );

  ms_timer #(
    .CNT_W (CNT_W),
    .LIMIT (REPEAT_DELAY_MS),
    .RELOAD(REPEAT_DELAY_MS - REPEAT_RATE_MS)
  ) u_repeat_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_ms),
    .clr   (rep_clr),
    .en    (rep_en),
    .done_c(rep_done)
  );

  ms_timer #(
    .CNT_W (CNT_W),
    .LIMIT (IDLE_TIMEOUT_MS),
    .RELOAD(0)
  ) u_idle_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_ms),
    .clr   (idle_clr),
    .en    (in_set),
    .done_c(idle_done)
  );

  always_comb begin
    armed_d      = armed_q;
    phase_d      = phase_q;
    inc_hrs_d    = 1'b0;
    inc_min_d    = 1'b0;
    clear_sec_d  = 1'b0;
    run_en_d     = 1'b0;
    blank_mask_d = '0;

    // Arming needs a release seen inside the current state.
    if (entry)         armed_d = 1'b0;
    else if (!adj_lvl) armed_d = 1'b1;

    if (blink_clr)       phase_d = 1'b0;
    else if (blink_done) phase_d = ~phase_q;

    if (!entry && (adj_act || rep_done)) begin
      inc_hrs_d = (state_q == ST_SET_HRS);
      inc_min_d = (state_q == ST_SET_MIN);
    end

    clear_sec_d = in_set && (state_d == ST_RUN);
    run_en_d    = (state_d == ST_RUN);

    if (phase_d && !adj_lvl) blank_mask_d = mask_for(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RUN;
      mode_q       <= 1'b0;
      adj_q        <= 1'b0;
      armed_q      <= 1'b0;
      phase_q      <= 1'b0;
      inc_min_q    <= 1'b0;
      inc_hrs_q    <= 1'b0;
      clear_sec_q  <= 1'b0;
      run_en_q     <= 1'b1;
      blank_mask_q <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_lvl;
      adj_q        <= adj_lvl;
      armed_q      <= armed_d;
      phase_q      <= phase_d;
      inc_min_q    <= inc_min_d;
      inc_hrs_q    <= inc_hrs_d;
      clear_sec_q  <= clear_sec_d;
      run_en_q     <= run_en_d;
      blank_mask_q <= blank_mask_d;
    end
  end

  assign inc_min    = inc_min_q;
  assign inc_hrs    = inc_hrs_q;
  assign clear_sec  = clear_sec_q;
  assign run_en     = run_en_q;
  assign blank_mask = blank_mask_q;
  assign mode       = state_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: directed scenarios then random button/tick
// traffic, every cycle compared against a tick-counting reference model.
module tb_time_set_controller;

  localparam int unsigned HALF   = 4;
  localparam int unsigned DELAY  = 6;
  localparam int unsigned RATE   = 3;
  localparam int unsigned IDLE_T = 20;

  logic       clk, reset, tick_ms, mode_lvl, adj_lvl;
  logic       inc_min, inc_hrs, clear_sec, run_en;
  logic [3:0] blank_mask;
  logic [1:0] mode;

  time_set_controller #(
    .BLINK_HALF_MS  (HALF),
    .REPEAT_DELAY_MS(DELAY),
    .REPEAT_RATE_MS (RATE),
    .IDLE_TIMEOUT_MS(IDLE_T),
    .CNT_W          (14)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick_ms   (tick_ms),
    .mode_lvl  (mode_lvl),
    .adj_lvl   (adj_lvl),
    .inc_min   (inc_min),
    .inc_hrs   (inc_hrs),
    .clear_sec (clear_sec),
    .run_en    (run_en),
    .blank_mask(blank_mask),
    .mode      (mode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_assert, n_fail, ncyc;
  int cnt_hrs, cnt_min, cnt_clr;
  bit cur_m, cur_a, cur_r;

  // Reference model: state as 0/1/2, tick counts since the relevant event.
  int         m_st, m_hold, m_idle, m_blink;
  bit         m_armed, m_pm, m_pa;
  logic [9:0] m_exp;

  function automatic logic [9:0] obs_vec();
    return {mode, blank_mask, run_en, clear_sec, inc_hrs, inc_min};
  endfunction

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit t, input bit m, input bit a, input bit r);
    int nst;
    bit chg, mp, ap, fire, phase, clr;
    logic [3:0] mask;
    if (r) begin
      m_st = 0; m_hold = 0; m_idle = 0; m_blink = 0;
      m_armed = 0; m_pm = 0; m_pa = 0;
      m_exp = 10'b00_0000_1_000;
      return;
    end
    mp = m && !m_pm;
    ap = a && !m_pa;
    if (m_st == 0 || mp || a) m_idle = 0;
    else if (t) m_idle++;
    nst = m_st;
    if (mp) nst = (m_st + 1) % 3;
    else if (m_st != 0 && m_idle == IDLE_T) nst = 0;
    chg = (nst != m_st);

    fire = 0;
    if (m_st != 0 && !chg && a && m_armed) begin
      if (ap) begin
        m_hold = 0;
        fire = 1;
      end else if (t) begin
        m_hold++;
        fire = (m_hold == DELAY) || (m_hold > DELAY && ((m_hold - DELAY) % RATE) == 0);
      end
    end else begin
      m_hold = 0;
    end

    m_armed = chg ? 1'b0 : (m_armed | !a);
    if (m_st == 0 || chg) m_blink = 0;
    else if (t) m_blink++;
    phase = ((m_blink / HALF) % 2) == 1;
    mask = 4'b0000;
    if (phase && !a && nst == 1) mask = 4'b1100;
    if (phase && !a && nst == 2) mask = 4'b0011;
    clr = (m_st != 0 && nst == 0);

    m_exp = {2'(nst), mask, 1'(nst == 0), clr, 1'(fire && m_st == 1), 1'(fire && m_st == 2)};
    m_st = nst;
    m_pm = m;
    m_pa = a;
  endtask

  task automatic cyc(input bit t);
    tick_ms  = t;
    mode_lvl = cur_m;
    adj_lvl  = cur_a;
    reset    = cur_r;
    @(posedge clk);
    model_step(t, cur_m, cur_a, cur_r);
    #1;
    check($sformatf("cycle%0d", ncyc), obs_vec(), m_exp);
    cnt_hrs += int'(inc_hrs);
    cnt_min += int'(inc_min);
    cnt_clr += int'(clear_sec);
    ncyc++;
  endtask

  task automatic press_mode();
    cur_m = 1'b1;
    cyc(1'b0);
    cur_m = 1'b0;
    cyc(1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1);
      cyc(1'b0);
    end
  endtask

  initial begin
    n_assert = 0; n_fail = 0; ncyc = 0;
    cnt_hrs = 0; cnt_min = 0; cnt_clr = 0;
    cur_m = 0; cur_a = 0; cur_r = 1;
    reset = 1'b1; tick_ms = 1'b0; mode_lvl = 1'b0; adj_lvl = 1'b0;

    cyc(1'b0);
    cyc(1'b0);
    check("reset_state", obs_vec(), 10'b00_0000_1_000);
    cur_r = 0;
    cyc(1'b0);

    // Mode sequencing RUN -> SET_HRS -> SET_MIN -> RUN.
    cnt_clr = 0;
    press_mode();
    check("mode_set_hrs", {8'b0, mode}, 10'd1);
    check("run_en_low_hrs", {9'b0, run_en}, 10'd0);
    press_mode();
    check("mode_set_min", {8'b0, mode}, 10'd2);
    check("run_en_low_min", {9'b0, run_en}, 10'd0);
    press_mode();
    check("mode_run", {8'b0, mode}, 10'd0);
    check("run_en_high", {9'b0, run_en}, 10'd1);
    check("clear_sec_pulses", 10'(cnt_clr), 10'd1);

    // Auto-repeat in SET_HRS.
    press_mode();
    cyc(1'b0);
    cyc(1'b0);
    cnt_hrs = 0;
    cur_a = 1;
    cyc(1'b0);
    check("inc_hrs_immediate", {9'b0, inc_hrs}, 10'd1);
    cyc(1'b0);
    check("inc_hrs_one_cycle", {9'b0, inc_hrs}, 10'd0);
    ticks(15);
    check("inc_hrs_repeat_count", 10'(cnt_hrs), 10'd5);
    cur_a = 0;
    cyc(1'b0);
    cyc(1'b0);

    // Adj held across RUN -> SET_HRS must not increment.
    press_mode();
    press_mode();
    cnt_hrs = 0; cnt_min = 0;
    cur_a = 1;
    cyc(1'b0);
    ticks(3);
    check("run_ignores_adj", 10'(cnt_hrs + cnt_min), 10'd0);
    press_mode();
    check("mode_hrs_adj_held", {8'b0, mode}, 10'd1);
    ticks(10);
    check("held_adj_no_inc", 10'(cnt_hrs + cnt_min), 10'd0);
    cur_a = 0;
    cyc(1'b0);
    cur_a = 1;
    cyc(1'b0);
    check("rearmed_inc_hrs", {9'b0, inc_hrs}, 10'd1);
    cur_a = 0;
    cyc(1'b0);
    check("rearmed_count", 10'(cnt_hrs), 10'd1);

    // Idle timeout in SET_MIN with blink pattern.
    press_mode();
    cnt_clr = 0;
    for (int k = 1; k <= int'(IDLE_T); k++) begin
      cyc(1'b1);
      if (k < int'(IDLE_T)) begin
        check($sformatf("blink_tick%0d", k), {6'b0, blank_mask},
              (((k / HALF) % 2) == 1) ? 10'd3 : 10'd0);
      end else begin
        check("idle_exit_mode", {8'b0, mode}, 10'd0);
        check("idle_exit_clear", {9'b0, clear_sec}, 10'd1);
      end
      cyc(1'b0);
    end
    check("idle_clear_pulses", 10'(cnt_clr), 10'd1);

    // Simultaneous mode and adj press in SET_HRS.
    press_mode();
    cyc(1'b0);
    cyc(1'b0);
    cnt_hrs = 0; cnt_min = 0;
    cur_m = 1; cur_a = 1;
    cyc(1'b0);
    check("simul_mode", {8'b0, mode}, 10'd2);
    check("simul_no_inc", {8'b0, inc_hrs, inc_min}, 10'd0);
    cur_m = 0;
    ticks(10);
    check("simul_no_inc_after", 10'(cnt_hrs + cnt_min), 10'd0);
    cur_a = 0;
    cyc(1'b0);

    // Reset mid SET_MIN with adj held.
    cur_a = 1;
    cyc(1'b0);
    ticks(2);
    cur_r = 1;
    cyc(1'b0);
    check("reset_mid_set", obs_vec(), 10'b00_0000_1_000);
    cur_r = 0;
    cnt_hrs = 0; cnt_min = 0;
    ticks(8);
    check("after_reset_no_inc", 10'(cnt_hrs + cnt_min), 10'd0);
    cur_a = 0;
    cyc(1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cur_r = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 39) == 0) cur_m = ~cur_m;
      if ($urandom_range(0, 24) == 0) cur_a = ~cur_a;
      cyc(1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
